// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL reset/lock sequencer with staggered
// per-domain reset release and bounded lock retries.
module pll_lock_seq #(
  parameter int NCH       = 3,
  parameter int RST_CYC   = 16,
  parameter int LOCK_CYC  = 64,
  parameter int TMO_CYC   = 4096,
  parameter int STAGGER   = 8,
  parameter int RETRY_MAX = 3
) (
  input  logic           refclk,
  input  logic           reset_n,
  input  logic           extlock,
  input  logic           clear,
  output logic           pll_rst,
  output logic [NCH-1:0] sys_rst_n,
  output logic           locked,
  output logic           fail,
  output logic [3:0]     retry_cnt
);

  localparam int M0 = (RST_CYC > LOCK_CYC) ? RST_CYC : LOCK_CYC;
  localparam int M1 = (M0 > TMO_CYC) ? M0 : TMO_CYC;
  localparam int M2 = (M1 > STAGGER * NCH) ? M1 : STAGGER * NCH;
  localparam int CW = $clog2(M2 + 1);

  typedef enum logic [2:0] {
    S_RSTPLL,
    S_WAIT,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     retry_q, retry_d;
  logic           prst_q, prst_d;
  logic [NCH-1:0] sys_q, sys_d;
  logic           lock_q, lock_d;
  logic           fail_q, fail_d;
  logic           s1_q, s2_q;
  logic [NCH-1:0] rel_mask;
  logic           adv, att_fail;

  // Two-flop synchroniser for the asynchronous lock input
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= extlock;
      s2_q <= s1_q;
    end
  end

  // Next state, shared counter, retry count and registered outputs
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    adv      = 1'b1;
    att_fail = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      rel_mask[i] = (STAGGER * i <= int'(cnt_q) + 1);
    end
    unique case (state_q)
      S_RSTPLL: begin
        if (cnt_q == CW'(RST_CYC - 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (s2_q) state_d = S_STABLE;
        else if (cnt_q == CW'(TMO_CYC - 1)) att_fail = 1'b1;
      end
      S_STABLE: begin
        if (!s2_q) state_d = S_WAIT;
        else if (cnt_q == CW'(LOCK_CYC - 1)) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!s2_q) att_fail = 1'b1;
        else if (&rel_mask) state_d = S_RUN;
      end
      S_RUN: begin
        adv = 1'b0;
        if (!s2_q) att_fail = 1'b1;
      end
      S_FAIL: begin
        adv = 1'b0;
      end
      default: state_d = S_RSTPLL;
    endcase
    if (att_fail) begin
      if (retry_q < 4'(RETRY_MAX)) begin
        retry_d = retry_q + 4'd1;
        state_d = S_RSTPLL;
      end else begin
        state_d = S_FAIL;
      end
    end
    if (clear) begin
      state_d = S_RSTPLL;
      retry_d = 4'd0;
    end
    if (clear || state_d != state_q) cnt_d = '0;
    else if (adv) cnt_d = cnt_q + CW'(1);
    else cnt_d = cnt_q;
    prst_d = (state_d == S_RSTPLL) || (state_d == S_FAIL);
    lock_d = (state_d == S_RELEASE) || (state_d == S_RUN);
    fail_d = (state_d == S_FAIL);
    sys_d  = '0;
    if (state_d == S_RUN) begin
      sys_d = '1;
    end else if (state_d == S_RELEASE) begin
      if (state_q == S_RELEASE) sys_d = rel_mask;
      else sys_d[0] = 1'b1;
    end
  end

  // State, counter and output registers
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RSTPLL;
      cnt_q   <= '0;
      retry_q <= 4'd0;
      prst_q  <= 1'b1;
      sys_q   <= '0;
      lock_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      prst_q  <= prst_d;
      sys_q   <= sys_d;
      lock_q  <= lock_d;
      fail_q  <= fail_d;
    end
  end

  assign pll_rst   = prst_q;
  assign sys_rst_n = sys_q;
  assign locked    = lock_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb_pll_lock_seq: directed timing checks plus randomized
// lock traffic against a phase/age reference model.
module tb_pll_lock_seq;

  localparam int NCH       = 3;
  localparam int RST_CYC   = 16;
  localparam int LOCK_CYC  = 64;
  localparam int TMO_CYC   = 4096;
  localparam int STAGGER   = 8;
  localparam int RETRY_MAX = 3;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_ON   = 3;
  localparam int P_FAIL = 4;

  logic           refclk  = 1'b0;
  logic           reset_n = 1'b1;
  logic           extlock = 1'b0;
  logic           clear   = 1'b0;
  logic           pll_rst;
  logic [NCH-1:0] sys_rst_n;
  logic           locked;
  logic           fail;
  logic [3:0]     retry_cnt;

  pll_lock_seq #(
    .NCH(NCH), .RST_CYC(RST_CYC), .LOCK_CYC(LOCK_CYC),
    .TMO_CYC(TMO_CYC), .STAGGER(STAGGER), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .refclk(refclk),
    .reset_n(reset_n),
    .extlock(extlock),
    .clear(clear),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .locked(locked),
    .fail(fail),
    .retry_cnt(retry_cnt)
  );

  always #5 refclk = ~refclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: phase, cycles since phase entry, retries
  int m_ph, m_age, m_ret;
  bit m_h[$];

  task automatic m_reset();
    m_ph  = P_RST;
    m_age = 0;
    m_ret = 0;
    m_h.delete();
    m_h.push_back(1'b0);
    m_h.push_back(1'b0);
  endtask

  task automatic m_go(input int p);
    m_ph  = p;
    m_age = 0;
  endtask

  task automatic m_fault();
    if (m_ret < RETRY_MAX) begin
      m_ret++;
      m_go(P_RST);
    end else begin
      m_go(P_FAIL);
    end
  endtask

  task automatic m_step(input bit lk, input bit clr);
    bit es;
    es = m_h.pop_front();
    m_h.push_back(lk);
    if (clr) begin
      m_go(P_RST);
      m_ret = 0;
      return;
    end
    case (m_ph)
      P_RST:
        if (m_age == RST_CYC - 1) m_go(P_WAIT);
        else m_age++;
      P_WAIT:
        if (es) m_go(P_STAB);
        else if (m_age == TMO_CYC - 1) m_fault();
        else m_age++;
      P_STAB:
        if (!es) m_go(P_WAIT);
        else if (m_age == LOCK_CYC - 1) m_go(P_ON);
        else m_age++;
      P_ON:
        if (!es) m_fault();
        else if (m_age < 1000000) m_age++;
      default: ;
    endcase
  endtask

  function automatic logic [NCH-1:0] m_sys();
    int n;
    if (m_ph != P_ON) return '0;
    n = m_age / STAGGER + 1;
    if (n > NCH) n = NCH;
    return NCH'((1 << n) - 1);
  endfunction

  task automatic check_all();
    chk("pll_rst", pll_rst, (m_ph == P_RST) || (m_ph == P_FAIL));
    chk("sys_rst_n", sys_rst_n, m_sys());
    chk("locked", locked, m_ph == P_ON);
    chk("fail", fail, m_ph == P_FAIL);
    chk("retry_cnt", retry_cnt, m_ret);
  endtask

  task automatic cyc(input bit lk, input bit clr);
    extlock = lk;
    clear   = clr;
    @(posedge refclk);
    m_step(lk, clr);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    check_all();
    @(posedge refclk);
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  int t_prst, t_lock, t_011, t_111, t_off, t_pr2, t_pf2;

  // extlock high from edge 27 (10 cycles after pll_rst falls)
  task automatic run_seq(input int n, input int glitch,
                         input int drop, input int clr_at);
    t_prst = 0; t_lock = 0; t_011 = 0; t_111 = 0;
    t_off = 0; t_pr2 = 0; t_pf2 = 0;
    for (int k = 1; k <= n; k++) begin
      bit lk;
      lk = (k >= 27) && (k != glitch) && (drop == 0 || k < drop);
      cyc(lk, k == clr_at);
      if (pll_rst === 1'b0 && t_prst == 0) t_prst = k;
      if (locked === 1'b1 && t_lock == 0) t_lock = k;
      if (sys_rst_n === 3'b011 && t_011 == 0) t_011 = k;
      if (sys_rst_n === 3'b111 && t_111 == 0) t_111 = k;
      if (t_lock != 0 && locked === 1'b0 && t_off == 0) t_off = k;
      if (t_off != 0 && pll_rst === 1'b1 && t_pr2 == 0) t_pr2 = k;
      if (t_pr2 != 0 && pll_rst === 1'b0 && t_pf2 == 0) t_pf2 = k;
    end
  endtask

  initial begin
    int t_fail, nhi, run;
    bit lk;

    // clean lock and staggered release
    do_reset();
    run_seq(130, 0, 0, 0);
    chk("prst_fall", t_prst, 16);
    chk("lock_rise", t_lock, 93);
    chk("sys011_at", t_011, 101);
    chk("sys111_at", t_111, 109);
    chk("ret_clean", retry_cnt, 0);

    // one-cycle glitch 30 cycles into STABLE
    do_reset();
    run_seq(140, 59, 0, 0);
    chk("glitch_lock", t_lock, 126);
    chk("glitch_ret", retry_cnt, 0);

    // lock loss in RUN
    do_reset();
    run_seq(160, 0, 130, 0);
    chk("loss_off", t_off, 132);
    chk("loss_prst", t_pr2, 132);
    chk("loss_width", t_pf2 - t_pr2, 16);
    chk("loss_ret", retry_cnt, 1);

    // clear coincident with lock loss while sys_rst_n=011
    do_reset();
    run_seq(125, 0, 103, 105);
    chk("cl_011", t_011, 101);
    chk("cl_off", t_off, 105);
    chk("cl_width", t_pf2 - t_pr2, 16);
    chk("cl_ret", retry_cnt, 0);

    // reset pulsed mid-release, then full restart
    do_reset();
    run_seq(100, 0, 0, 0);
    chk("mid_sys", sys_rst_n, 3'b001);
    do_reset();
    chk("rst_sys", sys_rst_n, 3'b000);
    chk("rst_prst", pll_rst, 1);
    run_seq(130, 0, 0, 0);
    chk("re_lock", t_lock, 93);
    chk("re_111", t_111, 109);

    // lock never arrives: retries then FAIL, then clear
    do_reset();
    t_fail = 0;
    for (int k = 1; k <= 16460; k++) begin
      cyc(1'b0, 1'b0);
      if (k == 4112) chk("to_ret1", retry_cnt, 1);
      if (k == 8224) chk("to_ret2", retry_cnt, 2);
      if (k == 12336) chk("to_ret3", retry_cnt, 3);
      if (fail === 1'b1 && t_fail == 0) t_fail = k;
    end
    chk("to_fail_at", t_fail, 16448);
    chk("to_ret_fin", retry_cnt, 3);
    chk("to_prst", pll_rst, 1);
    nhi = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, k == 1);
      if (k == 1) chk("clr_fail", fail, 0);
      if (k == 1) chk("clr_ret", retry_cnt, 0);
      if (pll_rst === 1'b1) nhi++;
    end
    chk("clr_width", nhi, 16);

    // randomized lock traffic with occasional clear
    do_reset();
    lk  = 1'b0;
    run = 0;
    for (int k = 0; k < 9000; k++) begin
      if (run == 0) begin
        lk = !lk;
        if (lk) run = int'($urandom_range(1, 300));
        else if ($urandom_range(0, 9) == 0)
          run = int'($urandom_range(100, 5000));
        else run = int'($urandom_range(1, 20));
      end
      run--;
      cyc(lk, $urandom_range(0, 699) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_seq.md
PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 Parameter NCH, default 3, number of downstream reset domains (1..16).
REQ-002 Parameter RST_CYC, default 16, refclk cycles pll_rst is held per attempt (>=2).
REQ-003 Parameter LOCK_CYC, default 64, consecutive synchronised-lock cycles required before lock is declared (>=1).
REQ-004 Parameter TMO_CYC, default 4096, lock-wait timeout in refclk cycles (>RST_CYC).
REQ-005 Parameter STAGGER, default 8, cycles between successive domain reset releases (>=1).
REQ-006 Parameter RETRY_MAX, default 3, failed attempts tolerated before FAIL (0..15).
REQ-007 refclk  in  1  sole clock; all state is in this domain.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 extlock  in  1  PLL lock indicator, asynchronous to refclk.
REQ-010 clear  in  1  synchronous pulse; restarts the sequence and clears retry count.
REQ-011 pll_rst  out  1  active-high reset driven to the PLL.
REQ-012 sys_rst_n  out  NCH  per-domain active-low resets, bit 0 released first.
REQ-013 locked  out  1  high while lock is declared (STABLE complete through RUN).
REQ-014 fail  out  1  high in FAIL state.
REQ-015 retry_cnt  out  4  failed attempts since last reset/clear, saturating at RETRY_MAX.

Function
REQ-016 extlock SHALL pass through a 2-flop synchroniser; extlock_s denotes its output (2-cycle latency); no other logic samples extlock.
REQ-017 FSM states SHALL be RSTPLL, WAIT, STABLE, RELEASE, RUN, FAIL, with one shared cycle counter cleared on every state transition.
REQ-018 RSTPLL: pll_rst=1; after RST_CYC cycles -> WAIT.
REQ-019 WAIT: pll_rst=0; extlock_s=1 -> STABLE; counter reaching TMO_CYC-1 with extlock_s=0 -> attempt failure.
REQ-020 STABLE: extlock_s=0 -> WAIT (timeout restarts, not an attempt failure); LOCK_CYC consecutive extlock_s=1 cycles -> RELEASE with locked=1.
REQ-021 RELEASE: sys_rst_n[i] SHALL go high STAGGER*i cycles after RELEASE entry (bit 0 on the entry cycle); after bit NCH-1 goes high -> RUN.
REQ-022 RUN: all sys_rst_n=1, locked=1; holds until lock loss or clear.
REQ-023 Lock loss (extlock_s=0 in RELEASE or RUN) SHALL, on the next edge, drive all sys_rst_n=0, locked=0, and count as an attempt failure.
REQ-024 Attempt failure: if retry_cnt<RETRY_MAX, retry_cnt+1 and -> RSTPLL; else -> FAIL, retry_cnt unchanged.
REQ-025 FAIL: pll_rst=1, sys_rst_n=all 0, locked=0, fail=1; exits only on clear.
REQ-026 clear=1 in any state SHALL force -> RSTPLL, retry_cnt=0, sys_rst_n=all 0, locked=0, fail=0 on the next edge; clear takes priority over lock loss and timeout in the same cycle.
REQ-027 sys_rst_n bits SHALL only ever rise in RELEASE, and SHALL all fall together; no partial de-assertion outside RELEASE.
REQ-028 Counter width SHALL be clog2 of max(RST_CYC, LOCK_CYC, TMO_CYC, STAGGER*NCH)+1; no wrap-around in any state.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 reset_n=0 SHALL immediately force state RSTPLL, counter=0, retry_cnt=0, pll_rst=1, sys_rst_n=all 0, locked=0, fail=0, synchroniser flops=0.
REQ-031 On reset_n rising, the sequence SHALL begin with a full RST_CYC-cycle pll_rst pulse; reset_n asserted mid-sequence SHALL abandon any in-progress release.

Verification
REQ-032 Defaults; extlock rises 10 cycles after pll_rst falls and stays -> pll_rst high 16 cycles, locked rises 2+64 cycles after extlock rise (+1 register), sys_rst_n = 001, 011, 111 at +0, +8, +16 cycles from locked, retry_cnt=0.
REQ-033 extlock glitches low 1 cycle at 30 cycles into STABLE -> return to WAIT, locked stays 0, retry_cnt=0, lock declared 64 cycles after recovery.
REQ-034 extlock held low -> WAIT timeout after 4096 cycles, retry_cnt 1,2,3 on successive attempts, 4th timeout -> fail=1, pll_rst=1, retry_cnt=3; clear pulse -> fail=0, retry_cnt=0, new 16-cycle pll_rst.
REQ-035 extlock drops in RUN -> sys_rst_n=000 and locked=0 within 3 cycles of drop, retry_cnt=1, pll_rst pulse of 16 cycles follows.
REQ-036 clear asserted same cycle as lock loss during RELEASE (sys_rst_n=011) -> sys_rst_n=000, retry_cnt=0, state RSTPLL.
REQ-037 reset_n pulsed low mid-RELEASE -> all outputs at reset values asynchronously, full sequence restarts on release.
